axis_frame_fifo: RTL and testbench

- Single-clock AXI4-Stream FIFO with frame (packet) mode; successor to the dual-clock stream FIFO.
- Output side sees only complete frames: a frame becomes readable only after its tlast word is written.
- Frames flagged bad (tuser=1 on tlast) are discarded; optional drop-on-overflow.
- Adds tkeep, occupancy count and per-frame status pulses; sits between MAC/parser stages.

---
 rtl/axis_fifo_pkg.sv | 15 +
 rtl/axis_fifo_mem.sv | 32 +++
 rtl/axis_frame_fifo.sv | 163 ++++++++++++++++
 tb/tb_axis_frame_fifo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the AXI4-Stream frame FIFO.
// Holds the write-FSM state encoding and the default storage geometry.
package axis_fifo_pkg;

   typedef enum logic [1:0] {
      WR_IDLE  = 2'd0,
      WR_FRAME = 2'd1,
      WR_DROP  = 2'd2
   } wr_state_e;

   localparam int ADDR_WIDTH_DEFAULT = 12;
   localparam int DEPTH              = 2**ADDR_WIDTH_DEFAULT;
   localparam int PTR_WIDTH          = ADDR_WIDTH_DEFAULT + 1;

endpackage

// File: rtl/axis_fifo_mem.sv
// Simple dual-port RAM for the frame FIFO: one write port and one registered read port.
// The read register doubles as the FIFO output data stage.
module axis_fifo_mem
   import axis_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH = PTR_WIDTH - 1,
   parameter int WORDS      = DEPTH,
   parameter int WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [WORDS];

   // NOTE: the array itself is never reset so it can map onto block RAM; only the read register is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/axis_frame_fifo.sv
// Single-clock AXI4-Stream frame FIFO: only complete frames reach the output, bad frames are discarded.
// Define AXIS_FRAME_FIFO_DROP_WHEN_FULL_EN to drop frames that do not fit instead of back-pressuring.
module axis_frame_fifo
   import axis_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH     = PTR_WIDTH - 1,
   parameter int DATA_WIDTH     = 8,
   parameter int KEEP_WIDTH     = (DATA_WIDTH + 7) / 8,
   parameter int DROP_BAD_FRAME = 1
) (
   input  logic                  clk,
   input  logic                  async_rst,
   input  logic [DATA_WIDTH-1:0] input_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
   input  logic                  input_axis_tvalid,
   output logic                  input_axis_tready,
   input  logic                  input_axis_tlast,
   input  logic                  input_axis_tuser,
   output logic [DATA_WIDTH-1:0] output_axis_tdata,
   output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
   output logic                  output_axis_tvalid,
   input  logic                  output_axis_tready,
   output logic                  output_axis_tlast,
   output logic                  output_axis_tuser,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  status_overflow,
   output logic                  status_bad_frame,
   output logic                  status_good_frame
);

   localparam int PW = ADDR_WIDTH + 1;

   typedef struct packed {
      logic                  last;
      logic                  user;
      logic [KEEP_WIDTH-1:0] keep;
      logic [DATA_WIDTH-1:0] data;
   } word_t;

   wr_state_e      state, state_nx;
   logic [PW-1:0]  wr_ptr_cur, wr_ptr_cur_nx;
   logic [PW-1:0]  wr_ptr, wr_ptr_nx;
   logic [PW-1:0]  rd_ptr, used;
   logic           full, empty, accept, wr_en, rd_en;
   logic           good_nx, bad_nx, out_valid;
   word_t          in_word, out_word;

   assign used   = wr_ptr_cur - rd_ptr;
   assign full   = (used == {1'b1, {ADDR_WIDTH{1'b0}}});
   assign empty  = (rd_ptr == wr_ptr);
   assign count  = used;
   assign accept = input_axis_tvalid & input_axis_tready;
   assign in_word = '{last: input_axis_tlast, user: input_axis_tuser,
                      keep: input_axis_tkeep, data: input_axis_tdata};

`ifdef AXIS_FRAME_FIFO_DROP_WHEN_FULL_EN
   logic ovf_nx, ovf_q;
   assign input_axis_tready = 1'b1;
   assign status_overflow   = ovf_q;
`else
   assign input_axis_tready = ~full;
   assign status_overflow   = 1'b0;
`endif

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_nx      = state;
      wr_ptr_cur_nx = wr_ptr_cur;
      wr_ptr_nx     = wr_ptr;
      wr_en         = 1'b0;
      good_nx       = 1'b0;
      bad_nx        = 1'b0;
`ifdef AXIS_FRAME_FIFO_DROP_WHEN_FULL_EN
      ovf_nx        = 1'b0;
`endif
      if (accept) begin
`ifdef AXIS_FRAME_FIFO_DROP_WHEN_FULL_EN
         if (state == WR_DROP) begin
            if (input_axis_tlast) state_nx = WR_IDLE;
         end else if (full) begin
            wr_ptr_cur_nx = wr_ptr;
            ovf_nx        = 1'b1;
            state_nx      = input_axis_tlast ? WR_IDLE : WR_DROP;
         end else
`endif
         begin
            wr_en         = 1'b1;
            wr_ptr_cur_nx = wr_ptr_cur + 1'b1;
            state_nx      = WR_FRAME;
            if (input_axis_tlast) begin
               state_nx = WR_IDLE;
               if ((DROP_BAD_FRAME != 0) && input_axis_tuser) begin
                  // Rewind: the frame's words stay in RAM but become overwritable.
                  wr_ptr_cur_nx = wr_ptr;
                  bad_nx        = 1'b1;
               end else begin
                  wr_ptr_nx = wr_ptr_cur + 1'b1;
                  good_nx   = 1'b1;
               end
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         state             <= WR_IDLE;
         wr_ptr_cur        <= '0;
         wr_ptr            <= '0;
         status_good_frame <= 1'b0;
         status_bad_frame  <= 1'b0;
      end else begin
         state             <= state_nx;
         wr_ptr_cur        <= wr_ptr_cur_nx;
         wr_ptr            <= wr_ptr_nx;
         status_good_frame <= good_nx;
         status_bad_frame  <= bad_nx;
      end
   end

`ifdef AXIS_FRAME_FIFO_DROP_WHEN_FULL_EN
   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) ovf_q <= 1'b0;
      else           ovf_q <= ovf_nx;
   end
`endif

   // Output stage refills whenever it is empty or being consumed.
   assign rd_en = (output_axis_tready | ~out_valid) & ~empty;

   always_ff @(posedge clk or posedge async_rst) begin
      if (async_rst) begin
         rd_ptr    <= '0;
         out_valid <= 1'b0;
      end else begin
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (output_axis_tready | ~out_valid) out_valid <= ~empty;
      end
   end

   axis_fifo_mem #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .WORDS      (2**ADDR_WIDTH),
      .WIDTH      ($bits(word_t))
   ) u_mem (
      .clk     (clk),
      .rst     (async_rst),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_cur[ADDR_WIDTH-1:0]),
      .wr_data (in_word),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
      .rd_data (out_word)
   );

   assign output_axis_tvalid = out_valid;
   assign output_axis_tdata  = out_word.data;
   assign output_axis_tkeep  = out_word.keep;
   assign output_axis_tlast  = out_word.last;
   assign output_axis_tuser  = (DROP_BAD_FRAME != 0) ? 1'b0 : out_word.user;

endmodule

// File: tb/tb_axis_frame_fifo.sv
// Self-checking bench for axis_frame_fifo (depth 8) against a queue-based frame model.
// Also covers the AXIS_FRAME_FIFO_DROP_WHEN_FULL_EN build when that macro is defined.
module tb_axis_frame_fifo;

   localparam int AW    = 3;
   localparam int DEPTH = 2**AW;

   logic        clk = 1'b0;
   logic        async_rst;
   logic [15:0] in_data;
   logic [1:0]  in_keep;
   logic        in_valid, in_ready, in_last, in_user;
   logic [15:0] out_data;
   logic [1:0]  out_keep;
   logic        out_valid, out_ready, out_last, out_user;
   logic [AW:0] count;
   logic        st_ovf, st_bad, st_good;

   int checks = 0;
   int errors = 0;

   axis_frame_fifo #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(16), .KEEP_WIDTH(2), .DROP_BAD_FRAME(1)
   ) dut (
      .clk(clk), .async_rst(async_rst),
      .input_axis_tdata(in_data), .input_axis_tkeep(in_keep),
      .input_axis_tvalid(in_valid), .input_axis_tready(in_ready),
      .input_axis_tlast(in_last), .input_axis_tuser(in_user),
      .output_axis_tdata(out_data), .output_axis_tkeep(out_keep),
      .output_axis_tvalid(out_valid), .output_axis_tready(out_ready),
      .output_axis_tlast(out_last), .output_axis_tuser(out_user),
      .count(count), .status_overflow(st_ovf),
      .status_bad_frame(st_bad), .status_good_frame(st_good)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: word = {last, user, keep, data}
   logic [19:0] cur_q[$];
   logic [19:0] exp_q[$];
   bit          m_in_reg, m_drop, good_exp, bad_exp, ovf_exp;
   int          words_out = 0, good_seen = 0, bad_seen = 0, ovf_seen = 0;
   logic [15:0] last_out_data;
   bit          rand_rdy = 0;

   always @(negedge clk) begin
      int          mem_words, committed_unloaded;
      bit          take, full;
      logic [19:0] head;
      if (async_rst) begin
         check("rst_tvalid", 32'(out_valid), 32'd0);
         check("rst_count", 32'(count), 32'd0);
         cur_q.delete(); exp_q.delete();
         m_in_reg = 0; m_drop = 0; good_exp = 0; bad_exp = 0; ovf_exp = 0;
      end else begin
         mem_words          = cur_q.size() + exp_q.size() - int'(m_in_reg);
         committed_unloaded = exp_q.size() - int'(m_in_reg);
         full               = (mem_words == DEPTH);
         check("count", 32'(count), 32'(mem_words));
         check("tvalid", 32'(out_valid), 32'(m_in_reg));
         check("good_pulse", 32'(st_good), 32'(good_exp));
         check("bad_pulse", 32'(st_bad), 32'(bad_exp));
         check("ovf_pulse", 32'(st_ovf), 32'(ovf_exp));
`ifdef AXIS_FRAME_FIFO_DROP_WHEN_FULL_EN
         check("in_ready", 32'(in_ready), 32'd1);
`else
         check("in_ready", 32'(in_ready), 32'(!full));
`endif
         good_seen += int'(st_good); bad_seen += int'(st_bad); ovf_seen += int'(st_ovf);
         good_exp = 0; bad_exp = 0; ovf_exp = 0;

         take = m_in_reg && out_ready;
         if (take) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               head = exp_q.pop_front();
               check("out_data", 32'(out_data), 32'(head[15:0]));
               check("out_keep", 32'(out_keep), 32'(head[17:16]));
               check("out_last", 32'(out_last), 32'(head[19]));
               check("out_user", 32'(out_user), 32'd0);
            end
            words_out++;
            last_out_data = out_data;
         end
         if (!m_in_reg || take) m_in_reg = (committed_unloaded > 0);

         if (in_valid && in_ready) begin
`ifdef AXIS_FRAME_FIFO_DROP_WHEN_FULL_EN
            if (m_drop) begin
               if (in_last) m_drop = 0;
            end else if (full) begin
               cur_q.delete();
               ovf_exp = 1;
               m_drop  = !in_last;
            end else
`endif
            begin
               cur_q.push_back({in_last, in_user, in_keep, in_data});
               if (in_last) begin
                  if (in_user) bad_exp = 1;
                  else begin
                     foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
                     good_exp = 1;
                  end
                  cur_q.delete();
               end
            end
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_word(input logic [15:0] d, input logic [1:0] k, input logic l, input logic u);
      bit acc;
      int n = 0;
      in_data = d; in_keep = k; in_last = l; in_user = u; in_valid = 1'b1;
      do begin
         acc = in_ready;
         tick();
         n++;
      end while (!acc && n < 200);
      in_valid = 1'b0;
      if (!acc) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_frame(input int len, input bit bad, input bit rnd, input logic [15:0] base);
      for (int i = 0; i < len; i++) begin
         if (rnd && $urandom_range(0, 3) == 0) tick();
         send_word(rnd ? 16'($urandom) : base + 16'(i), rnd ? 2'($urandom) : 2'b11,
                   i == len - 1, bad && (i == len - 1));
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || m_in_reg) && n < 400) begin
         tick();
         n++;
      end
      check("drain_timeout", 32'(n < 400), 32'd1);
      check("drain_count", 32'(count), 32'd0);
   endtask

   initial begin
      int w0, g0, b0, o0, exp_total;
      async_rst = 1'b1;
      in_data = '0; in_keep = '0; in_valid = 1'b0; in_last = 1'b0; in_user = 1'b0;
      out_ready = 1'b1;
      #2;
      check("reset_tvalid", 32'(out_valid), 32'd0);
      check("reset_count", 32'(count), 32'd0);
      check("reset_status", 32'({st_ovf, st_bad, st_good}), 32'd0);
      check("reset_ready", 32'(in_ready), 32'd1);
      tick(); tick();
      async_rst = 1'b0;
      tick();

      // Three-word frame and first-word latency
      g0 = good_seen; w0 = words_out;
      send_word(16'h00A1, 2'b11, 1'b0, 1'b0);
      send_word(16'h00A2, 2'b11, 1'b0, 1'b0);
      send_word(16'h00A3, 2'b11, 1'b1, 1'b0);
      check("lat_edge_n_tvalid", 32'(out_valid), 32'd0);
      check("lat_good_pulse", 32'(st_good), 32'd1);
      tick();
      check("lat_edge_n1_tvalid", 32'(out_valid), 32'd1);
      check("lat_first_data", 32'(out_data), 32'h00A1);
      drain();
      check("a_good_count", 32'(good_seen - g0), 32'd1);
      check("a_words_out", 32'(words_out - w0), 32'd3);

      // Bad frame then a good single word
      g0 = good_seen; b0 = bad_seen; w0 = words_out;
      send_frame(2, 1'b1, 1'b0, 16'h0B00);
      send_word(16'h0055, 2'b11, 1'b1, 1'b0);
      drain();
      check("bad_pulses", 32'(bad_seen - b0), 32'd1);
      check("bad_good_pulses", 32'(good_seen - g0), 32'd1);
      check("bad_words_out", 32'(words_out - w0), 32'd1);
      check("bad_last_data", 32'(last_out_data), 32'h0055);

      // Full-depth frame with output stalled
      out_ready = 1'b0;
      w0 = words_out;
      send_frame(DEPTH, 1'b0, 1'b0, 16'h0C00);
      check("full_count", 32'(count), 32'(DEPTH));
`ifndef AXIS_FRAME_FIFO_DROP_WHEN_FULL_EN
      check("full_ready", 32'(in_ready), 32'd0);
`endif
      out_ready = 1'b1;
      drain();
      check("full_words_out", 32'(words_out - w0), 32'(DEPTH));
      check("full_ready_back", 32'(in_ready), 32'd1);

`ifdef AXIS_FRAME_FIFO_DROP_WHEN_FULL_EN
      // Oversized frame is dropped, the next frame survives
      o0 = ovf_seen; w0 = words_out;
      send_frame(DEPTH + 2, 1'b0, 1'b0, 16'h0D00);
      send_frame(2, 1'b0, 1'b0, 16'h0E00);
      drain();
      check("ovf_pulses", 32'(ovf_seen - o0), 32'd1);
      check("ovf_words_out", 32'(words_out - w0), 32'd2);
      check("ovf_last_data", 32'(last_out_data), 32'h0E01);
`else
      o0 = ovf_seen;
`endif

      // Reset mid-frame, then mid-output
      send_word(16'h0F01, 2'b11, 1'b0, 1'b0);
      send_word(16'h0F02, 2'b11, 1'b0, 1'b0);
      async_rst = 1'b1;
      #1;
      check("rst_mid_frame_count", 32'(count), 32'd0);
      tick();
      async_rst = 1'b0;
      out_ready = 1'b0;
      send_word(16'h0077, 2'b11, 1'b1, 1'b0);
      tick();
      check("pre_rst_tvalid", 32'(out_valid), 32'd1);
      async_rst = 1'b1;
      #1;
      check("rst_mid_out_tvalid", 32'(out_valid), 32'd0);
      check("rst_mid_out_count", 32'(count), 32'd0);
      tick();
      async_rst = 1'b0;
      out_ready = 1'b1;
      w0 = words_out;
      send_word(16'h00AA, 2'b11, 1'b1, 1'b0);
      drain();
      check("post_rst_words_out", 32'(words_out - w0), 32'd1);
      check("post_rst_data", 32'(last_out_data), 32'h00AA);

      // Random traffic with random output back-pressure
      w0 = words_out;
      exp_total = 0;
      rand_rdy = 1;
      for (int f = 0; f < 200; f++) begin
         int len;
         bit bad;
         len = $urandom_range(1, 6);
         bad = ($urandom_range(0, 4) == 0);
         if (!bad) exp_total += len;
         send_frame(len, bad, 1'b1, 16'h0);
      end
      rand_rdy = 0;
      out_ready = 1'b1;
      drain();
`ifndef AXIS_FRAME_FIFO_DROP_WHEN_FULL_EN
      check("rand_words_out", 32'(words_out - w0), 32'(exp_total));
      check("no_overflow", 32'(ovf_seen - o0), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
